pseudo_softmax_scheduler: RTL and testbench
===========================================

PSEUDO_SOFTMAX_SCHEDULER -- requirements
Module: pseudo_softmax_scheduler

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 10, number of vector elements.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, width of each element, mantissa and exponent field.
REQ-003 SHALL have parameter LATENCY, default 4, datapath cycles from a stable x bus to valid mant/exp; legal range 1..15.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports in_valid input 1, in_ready output 1, in_data input NUM_INPUTS*DATA_WIDTH: input vector handshake, element i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port dp_x, output, NUM_INPUTS*DATA_WIDTH, vector driven to the pseudo-softmax datapath x inputs.
REQ-008 SHALL have ports dp_mant input DATA_WIDTH and dp_exp input NUM_INPUTS*DATA_WIDTH: datapath mant_out and exp_out bus.
REQ-009 SHALL have ports out_valid output 1, out_ready input 1, out_mant output DATA_WIDTH, out_exp output NUM_INPUTS*DATA_WIDTH: result handshake.
REQ-010 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-011 SHALL have port vec_count, output, 16, count of completed output handshakes.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT, OUT; one vector in flight at most.
REQ-013 SHALL drive in_ready = 1 only in IDLE; out_valid = 1 only in OUT.
REQ-014 SHALL, on edge with in_valid & in_ready, load in_data into the input register, load wait counter with LATENCY-1, go to WAIT.
REQ-015 SHALL drive dp_x from the input register at all times; register unchanged outside an accept edge.
REQ-016 SHALL, in WAIT, decrement counter each edge while non-zero; on edge with counter == 0 capture dp_mant/dp_exp into out_mant/out_exp and go to OUT.
REQ-017 SHALL therefore raise out_valid exactly LATENCY edges after the accepting edge.
REQ-018 SHALL hold out_mant, out_exp stable while out_valid high and out_ready low (backpressure, unbounded).
REQ-019 SHALL, on edge with out_valid & out_ready, go to IDLE and increment vec_count by 1, wrapping 0xFFFF -> 0x0000.
REQ-020 SHALL ignore in_valid outside IDLE; in_data changes in WAIT/OUT do not affect dp_x or results.
REQ-021 SHALL ignore out_ready outside OUT.
REQ-022 SHALL, with LATENCY = 1, capture on the first edge after accept (counter loaded 0).

Reset
REQ-023 SHALL, on rst_n low, immediately and asynchronously force state IDLE, counter 0, input register 0, out_mant 0, out_exp 0, vec_count 0, out_valid 0, busy 0, in_ready 1 after reset release.
REQ-024 SHALL, on reset mid-WAIT or mid-OUT, discard the in-flight vector with no output handshake and no vec_count change.
REQ-025 SHALL accept a vector on the first rising edge after rst_n deasserts if in_valid high.

Configuration
REQ-026 SHALL, with macro PSEUDO_SOFTMAX_ARGMAX_EN defined, add output out_argmax, width 4, index of the largest element of the accepted in_data (unsigned compare, lowest index on ties), registered on the accepting edge, 0 at reset, held stable with out_exp.
REQ-027 SHALL, without PSEUDO_SOFTMAX_ARGMAX_EN, omit out_argmax port and its logic; all other behaviour identical.

Verification
REQ-028 SHALL cover basic flow: LATENCY=4, accept at edge 10, dp_mant=0x5A -> out_valid high after edge 14, out_mant=0x5A, vec_count 0 -> 1 on handshake.
REQ-029 SHALL cover backpressure: out_ready low 20 cycles while dp inputs change -> out_mant/out_exp unchanged, in_ready low, second in_valid not accepted.
REQ-030 SHALL cover reset mid-WAIT: rst_n low 2 cycles after accept -> out_valid never rises, vec_count stays 0, in_ready 1 after release.
REQ-031 SHALL cover wrap: preset 65535 handshakes (or force) -> next handshake gives vec_count 0x0000.
REQ-032 SHALL cover LATENCY=1: accept at edge 5 -> out_valid after edge 6; back-to-back in/out ready high -> one vector per 3 edges.
REQ-033 SHALL cover ARGMAX_EN: in_data elements {3,9,9,1,0,0,0,0,0,0} -> out_argmax = 1.

Source files
------------

// File: rtl/pseudo_softmax_scheduler.sv
// -----------------------------------------------------------------------------
// pseudo_softmax_scheduler
//
// Purpose:
//   Feeds one input vector at a time into an external pseudo-softmax
//   datapath. It holds the vector on dp_x, waits LATENCY cycles for the
//   datapath to settle, captures the mant/exp result, and presents it on
//   a valid/ready output port until it is consumed.
//
// Handshake semantics (both ports):
//   A transfer happens on a rising clk edge where valid and ready are both
//   high. in_ready is high only in IDLE; out_valid is high only in OUT.
//   Once out_valid is high, out_mant/out_exp hold until the transfer.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  input vector handshake, in_data element i at
//                      [i*DATA_WIDTH +: DATA_WIDTH]
//   dp_x               registered vector driven into the datapath
//   dp_mant, dp_exp    datapath results, sampled LATENCY edges after accept
//   out_valid/ready    result handshake, out_mant / out_exp payload
//   busy               high whenever the FSM is not IDLE
//   vec_count          completed output transfers, wraps at 16 bits
//   o_dbg_state        current FSM state (IDLE=0, WAIT=1, OUT=2)
//
// Optional feature (macro PSEUDO_SOFTMAX_ARGMAX_EN):
//   Adds out_argmax, index of the largest accepted element (unsigned,
//   lowest index wins ties), registered on the accepting edge.
// -----------------------------------------------------------------------------
module pseudo_softmax_scheduler #(
   parameter int NUM_INPUTS = 10,
   parameter int DATA_WIDTH = 8,
   parameter int LATENCY    = 4
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
   output logic [NUM_INPUTS*DATA_WIDTH-1:0] dp_x,
   input  logic [DATA_WIDTH-1:0]            dp_mant,
   input  logic [NUM_INPUTS*DATA_WIDTH-1:0] dp_exp,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [DATA_WIDTH-1:0]            out_mant,
   output logic [NUM_INPUTS*DATA_WIDTH-1:0] out_exp,
   output logic                             busy,
   output logic [15:0]                      vec_count,
`ifdef PSEUDO_SOFTMAX_ARGMAX_EN
   output logic [3:0]                       out_argmax,
`endif
   output logic [1:0]                       o_dbg_state
);

   localparam int VW = NUM_INPUTS * DATA_WIDTH;
   // Loading LATENCY-1 makes the capture land exactly LATENCY edges after accept.
   localparam logic [3:0] LP_CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_OUT  = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic [3:0]            r_cnt;
   logic [VW-1:0]         r_x;
   logic [DATA_WIDTH-1:0] r_mant;
   logic [VW-1:0]         r_exp;
   logic [15:0]           r_vec_count;
   logic                  w_accept;
   logic                  w_capture;
   logic                  w_out_hs;

   assign w_accept  = in_valid  && (r_state == S_IDLE);
   assign w_capture = (r_state == S_WAIT) && (r_cnt == 4'd0);
   assign w_out_hs  = out_ready && (r_state == S_OUT);

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and state-decoded outputs
   always_comb begin
      w_next_state = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      busy         = 1'b1;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (w_accept) w_next_state = S_WAIT;
         end
         S_WAIT: begin
            if (w_capture) w_next_state = S_OUT;
         end
         S_OUT: begin
            out_valid = 1'b1;
            if (w_out_hs) w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // Input register, wait counter, result capture, transfer counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= 4'd0;
         r_x         <= '0;
         r_mant      <= '0;
         r_exp       <= '0;
         r_vec_count <= 16'd0;
      end else begin
         if (w_accept) begin
            r_x   <= in_data;
            r_cnt <= LP_CNT_INIT;
         end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_capture) begin
            r_mant <= dp_mant;
            r_exp  <= dp_exp;
         end
         if (w_out_hs) begin
            r_vec_count <= r_vec_count + 16'd1;
         end
      end
   end

`ifdef PSEUDO_SOFTMAX_ARGMAX_EN
   logic [3:0]            r_argmax;
   logic [3:0]            w_argmax;
   logic [DATA_WIDTH-1:0] w_max;

   // Strict greater-than keeps the lowest index on ties.
   always_comb begin
      w_argmax = 4'd0;
      w_max    = in_data[DATA_WIDTH-1:0];
      for (int i = 1; i < NUM_INPUTS; i++) begin
         if (in_data[i*DATA_WIDTH +: DATA_WIDTH] > w_max) begin
            w_max    = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            w_argmax = 4'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_argmax <= 4'd0;
      end else if (w_accept) begin
         r_argmax <= w_argmax;
      end
   end

   assign out_argmax = r_argmax;
`endif

   assign dp_x        = r_x;
   assign out_mant    = r_mant;
   assign out_exp     = r_exp;
   assign vec_count   = r_vec_count;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pseudo_softmax_scheduler.sv
// -----------------------------------------------------------------------------
// tb_pseudo_softmax_scheduler
//
// Two instances share clk/rst_n: dut_a with LATENCY=4 and dut_b with
// LATENCY=1. Each datapath is modelled combinationally from dp_x, with a
// noise term that can disturb it while results must be held.
// -----------------------------------------------------------------------------
module tb_pseudo_softmax_scheduler;

   localparam int NI = 10;
   localparam int DW = 8;
   localparam int VW = NI * DW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;

   // dut_a signals
   logic          in_valid_a = 1'b0, out_ready_a = 1'b0;
   logic          in_ready_a, out_valid_a, busy_a;
   logic [VW-1:0] in_data_a = '0, dp_x_a, dp_exp_a, out_exp_a;
   logic [DW-1:0] dp_mant_a, out_mant_a;
   logic [15:0]   vec_a;
   logic [1:0]    dbg_a;
   logic [DW-1:0] noise_a = '0;
   // dut_b signals
   logic          in_valid_b = 1'b0, out_ready_b = 1'b0;
   logic          in_ready_b, out_valid_b, busy_b;
   logic [VW-1:0] in_data_b = '0, dp_x_b, dp_exp_b, out_exp_b;
   logic [DW-1:0] dp_mant_b, out_mant_b;
   logic [15:0]   vec_b;
   logic [1:0]    dbg_b;
`ifdef PSEUDO_SOFTMAX_ARGMAX_EN
   logic [3:0]    arg_a, arg_b;
   logic [3:0]    exp_arg_q[$];
`endif

   // scoreboard
   logic [DW-1:0] exp_mant_q[$];
   logic [VW-1:0] exp_exp_q[$];
   logic [15:0]   exp_vec_a = 16'd0;
   int            n_checks = 0;
   int            n_fail = 0;

   // datapath model
   function automatic logic [DW-1:0] f_mant(input logic [VW-1:0] x);
      logic [DW-1:0] s;
      s = 8'h00;
      for (int i = 0; i < NI; i++) s = s + x[i*DW +: DW];
      return s ^ 8'hA5;
   endfunction

   function automatic logic [VW-1:0] f_exp(input logic [VW-1:0] x);
      logic [VW-1:0] r;
      for (int i = 0; i < NI; i++) r[i*DW +: DW] = x[i*DW +: DW] + 8'(i + 1);
      return r;
   endfunction

   // scan from the top with >= so the lowest index wins ties
   function automatic logic [3:0] f_argmax(input logic [VW-1:0] x);
      logic [3:0]    idx;
      logic [DW-1:0] m;
      idx = 4'(NI - 1);
      m   = x[(NI-1)*DW +: DW];
      for (int i = NI - 2; i >= 0; i--) begin
         if (x[i*DW +: DW] >= m) begin
            m   = x[i*DW +: DW];
            idx = 4'(i);
         end
      end
      return idx;
   endfunction

   assign dp_mant_a = f_mant(dp_x_a) ^ noise_a;
   assign dp_exp_a  = f_exp(dp_x_a) ^ {NI{noise_a}};
   assign dp_mant_b = f_mant(dp_x_b);
   assign dp_exp_b  = f_exp(dp_x_b);

   pseudo_softmax_scheduler #(.NUM_INPUTS(NI), .DATA_WIDTH(DW), .LATENCY(4)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
      .dp_x(dp_x_a), .dp_mant(dp_mant_a), .dp_exp(dp_exp_a),
      .out_valid(out_valid_a), .out_ready(out_ready_a),
      .out_mant(out_mant_a), .out_exp(out_exp_a),
      .busy(busy_a), .vec_count(vec_a),
`ifdef PSEUDO_SOFTMAX_ARGMAX_EN
      .out_argmax(arg_a),
`endif
      .o_dbg_state(dbg_a)
   );

   pseudo_softmax_scheduler #(.NUM_INPUTS(NI), .DATA_WIDTH(DW), .LATENCY(1)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
      .dp_x(dp_x_b), .dp_mant(dp_mant_b), .dp_exp(dp_exp_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b),
      .out_mant(out_mant_b), .out_exp(out_exp_b),
      .busy(busy_b), .vec_count(vec_b),
`ifdef PSEUDO_SOFTMAX_ARGMAX_EN
      .out_argmax(arg_b),
`endif
      .o_dbg_state(dbg_b)
   );

   // clock / reset block
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [VW-1:0] rand_vec();
      logic [VW-1:0] v;
      for (int i = 0; i < NI; i++) v[i*DW +: DW] = 8'($urandom_range(0, 255));
      return v;
   endfunction

   // driver: called at a negedge; returns 1 ns after the accepting edge
   task automatic send_a(input logic [VW-1:0] d);
      int waited;
      waited = 0;
      while (!in_ready_a && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      check("send_a_ready_timeout", (waited < 50), 1'b1);
      in_data_a  = d;
      in_valid_a = 1'b1;
      exp_mant_q.push_back(f_mant(d));
      exp_exp_q.push_back(f_exp(d));
`ifdef PSEUDO_SOFTMAX_ARGMAX_EN
      exp_arg_q.push_back(f_argmax(d));
`endif
      @(posedge clk);
      #1 in_valid_a = 1'b0;
   endtask

   // monitor/consumer: latency check, hold under backpressure, transfer
   task automatic recv_a(input int hold);
      int            lat;
      logic [VW-1:0] held_x;
      logic [DW-1:0] m;
      logic [VW-1:0] e;
      held_x = dp_x_a;
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         in_data_a = rand_vec();   // must not reach dp_x outside IDLE
      end while (!out_valid_a && lat < 64);
      check("latency_a", lat, 4);
      check("dp_x_stable_wait", dp_x_a, held_x);
      check("sb_nonempty", (exp_mant_q.size() > 0), 1'b1);
      if (exp_mant_q.size() > 0) begin
         m = exp_mant_q.pop_front();
         e = exp_exp_q.pop_front();
         check("out_mant_a", out_mant_a, m);
         check("out_exp_a", out_exp_a, e);
`ifdef PSEUDO_SOFTMAX_ARGMAX_EN
         check("out_argmax_a", arg_a, exp_arg_q.pop_front());
`endif
         for (int c = 0; c < hold; c++) begin
            noise_a    = 8'($urandom_range(1, 255));
            in_valid_a = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", out_valid_a, 1'b1);
            check("hold_in_ready", in_ready_a, 1'b0);
            check("hold_mant", out_mant_a, m);
            check("hold_exp", out_exp_a, e);
         end
      end
      out_ready_a = 1'b1;
      @(posedge clk);
      #1;
      out_ready_a = 1'b0;
      in_valid_a  = 1'b0;
      noise_a     = '0;
      exp_vec_a   = exp_vec_a + 16'd1;
      @(negedge clk);
      check("vec_a", vec_a, exp_vec_a);
      check("idle_after_hs", busy_a, 1'b0);
      check("dp_x_not_reloaded", dp_x_a, held_x);
   endtask

   initial begin
      logic [VW-1:0] d;
      int            lat;
      int            seen;
      logic [15:0]   base_b;

      // reset values
      repeat (3) @(negedge clk);
      check("rst_out_valid", out_valid_a, 1'b0);
      check("rst_busy", busy_a, 1'b0);
      check("rst_vec", vec_a, 16'd0);
      check("rst_dp_x", dp_x_a, '0);
      check("rst_mant", out_mant_a, '0);
      check("rst_exp", out_exp_a, '0);
      check("rst_state", dbg_a, 2'd0);
`ifdef PSEUDO_SOFTMAX_ARGMAX_EN
      check("rst_argmax", arg_a, 4'd0);
`endif
      rst_n = 1'b1;
      check("rst_in_ready", in_ready_a, 1'b1);

      // accept on the first edge after release, then reset mid-WAIT
      d = rand_vec();
      send_a(d);
      check("first_edge_accept", dp_x_a, d);
      check("busy_wait", busy_a, 1'b1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async_rst_busy", busy_a, 1'b0);
      check("async_rst_dp_x", dp_x_a, '0);
      exp_mant_q.delete();
      exp_exp_q.delete();
`ifdef PSEUDO_SOFTMAX_ARGMAX_EN
      exp_arg_q.delete();
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (out_valid_a) seen++;
      end
      check("rst_wait_no_valid", seen, 0);
      check("rst_wait_vec", vec_a, 16'd0);
      check("rst_wait_in_ready", in_ready_a, 1'b1);

      // basic flow
      d = '0;
      for (int i = 0; i < NI; i++) d[i*DW +: DW] = 8'(i * 17 + 3);
      send_a(d);
      recv_a(0);

      // backpressure: 20 held cycles with disturbed datapath and a second in_valid
      send_a(rand_vec());
      recv_a(20);

      // random vectors and short holds
      for (int k = 0; k < 4; k++) begin
         send_a(rand_vec());
         recv_a($urandom_range(0, 3));
      end

      // tie case for argmax: {3,9,9,1,0,...} -> 1
      d = '0;
      d[0*DW +: DW] = 8'd3;
      d[1*DW +: DW] = 8'd9;
      d[2*DW +: DW] = 8'd9;
      d[3*DW +: DW] = 8'd1;
      send_a(d);
`ifdef PSEUDO_SOFTMAX_ARGMAX_EN
      check("argmax_tie", arg_a, 4'd1);
`endif
      recv_a(1);

      // counter wrap
      force dut_a.r_vec_count = 16'hFFFF;
      @(negedge clk);
      release dut_a.r_vec_count;
      @(negedge clk);
      check("vec_preset", vec_a, 16'hFFFF);
      exp_vec_a = 16'hFFFF;
      send_a(rand_vec());
      recv_a(0);
      check("vec_wrap", vec_a, 16'h0000);

      // LATENCY=1: single vector
      d = rand_vec();
      in_data_b  = d;
      in_valid_b = 1'b1;
      @(posedge clk);
      #1 in_valid_b = 1'b0;
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (!out_valid_b && lat < 16);
      check("latency_b", lat, 1);
      check("out_mant_b", out_mant_b, f_mant(d));
      check("out_exp_b", out_exp_b, f_exp(d));
      out_ready_b = 1'b1;
      @(posedge clk);
      #1 out_ready_b = 1'b0;
      @(negedge clk);
      check("vec_b_single", vec_b, 16'd1);

      // LATENCY=1 streaming: one vector every 3 edges
      base_b = vec_b;
      d = rand_vec();
      in_data_b   = d;
      in_valid_b  = 1'b1;
      out_ready_b = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         check("stream_vec_b", vec_b, base_b + 16'(k / 3));
         check("stream_valid_b", out_valid_b, (k % 3 == 2));
         if (out_valid_b) check("stream_mant_b", out_mant_b, f_mant(d));
      end
      in_valid_b  = 1'b0;
      out_ready_b = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
